// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/writeback sequencer for the multi-cycle core,
// with memory-handshake timeout, sticky illegal/bus-error traps and a retired-instruction counter.
module multicycle_control #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret
);
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5, TRAP = 3'd6;
    localparam logic [6:0] OP_ADDI = 7'h1b, OP_ORI = 7'h13, OP_R = 7'h33, OP_LD = 7'h03, OP_ST = 7'h23,
                           OP_LUI = 7'h38, OP_JAL = 7'h6f, OP_JALR = 7'h67, OP_BR = 7'h63;

    logic [2:0]      state, next;
    logic [TO_W-1:0] cnt;
    logic            legal, waiting, timeout, retire, taken, link, src_b, flow;
    logic [1:0]      op_sel;

    always_comb begin
        legal   = (opcode inside {OP_ADDI, OP_ORI, OP_R, OP_LD, OP_ST, OP_LUI, OP_JAL, OP_JALR}) ||
                  (opcode == OP_BR && funct3[2:1] == 2'b00);
        waiting = (state == FETCH || state == MEM) && !mem_ready;
        timeout = waiting && cnt == TO_W'(TIMEOUT);
        flow    = opcode inside {OP_BR, OP_JAL, OP_JALR};
        taken   = opcode == OP_BR && (funct3[0] ^ alu_zero);
        link    = opcode == OP_JAL || opcode == OP_JALR;
        src_b   = !(opcode == OP_R || opcode == OP_BR);
        op_sel  = (opcode == OP_ORI || opcode == OP_R) ? 2'b10 :
                  opcode == OP_LUI ? 2'b11 : opcode == OP_BR ? 2'b01 : 2'b00;
        retire  = (state == EXEC && flow) || (state == MEM && mem_ready && opcode == OP_ST) || state == WB;
    end

    // The wait counter restarts on every state change, so it only ever measures the current FETCH/MEM stay.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            instret <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state   <= next;
            cnt     <= (next != state) ? '0 : cnt + TO_W'(waiting);
            instret <= instret + 32'(retire);
            if (state == DECODE && !legal) illegal <= 1'b1;
            if (timeout) bus_err <= 1'b1;
        end

    always_comb begin
        next = TRAP;
        case (state)
            IDLE:    next = FETCH;
            FETCH:   next = mem_ready ? DECODE : timeout ? TRAP : FETCH;
            DECODE:  next = legal ? EXEC : TRAP;
            EXEC:    next = (opcode == OP_LD || opcode == OP_ST) ? MEM : flow ? FETCH : WB;
            MEM:     next = mem_ready ? (opcode == OP_ST ? FETCH : WB) : timeout ? TRAP : MEM;
            WB:      next = FETCH;
            default: next = TRAP;
        endcase
    end

    // Gating with rst makes strobes fall the moment reset rises, independent of the state register.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        if (!rst)
            case (state)
                FETCH: if (!timeout) begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                EXEC: begin
                    alu_src_b = src_b;
                    alu_op    = op_sel;
                    reg_write = link;
                    wb_sel    = link ? 2'b10 : 2'b00;
                    pc_write  = taken || link;
                    pc_src    = opcode == OP_JALR ? 2'b10 : (opcode == OP_BR || opcode == OP_JAL) ? 2'b01 : 2'b00;
                end
                MEM: if (!timeout) begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_we    = opcode == OP_ST;
                    alu_src_b = 1'b1;
                    alu_op    = 2'b00;
                end
                WB: begin
                    reg_write = 1'b1;
                    wb_sel    = opcode == OP_LD ? 2'b01 : 2'b00;
                    alu_src_b = src_b;
                    alu_op    = op_sel;
                end
                default: ;
            endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-instruction expected output traces checked every cycle, directed plus random.
module tb_multicycle_control;
    localparam int TO = 4;

    typedef struct packed {
        logic mem_req, mem_we, iord, ir_write, pc_write;
        logic [1:0] pc_src;
        logic alu_src_b;
        logic [1:0] alu_op;
        logic reg_write;
        logic [1:0] wb_sel;
        logic illegal, bus_err;
        logic [31:0] instret;
        logic chk_alu;
    } exp_t;

    logic clk = 1'b0, rst = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic alu_zero = 1'b0, mem_ready = 1'b0;
    logic mem_req, mem_we, iord, ir_write, pc_write, alu_src_b, reg_write, illegal, bus_err;
    logic [1:0] pc_src, alu_op, wb_sel;
    logic [31:0] instret;

    int vectors = 0, miscompares = 0;
    exp_t ex;
    logic ex_valid = 1'b0;
    logic [31:0] m_ir = '0;
    logic m_ill = 1'b0, m_be = 1'b0, trapped = 1'b0;

    multicycle_control #(.TO_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
        .illegal(illegal), .bus_err(bus_err), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) if (ex_valid) begin
        chk("mem_req", 32'(mem_req), 32'(ex.mem_req));
        chk("mem_we", 32'(mem_we), 32'(ex.mem_we));
        chk("ir_write", 32'(ir_write), 32'(ex.ir_write));
        chk("pc_write", 32'(pc_write), 32'(ex.pc_write));
        chk("reg_write", 32'(reg_write), 32'(ex.reg_write));
        chk("illegal", 32'(illegal), 32'(ex.illegal));
        chk("bus_err", 32'(bus_err), 32'(ex.bus_err));
        chk("instret", instret, ex.instret);
        if (ex.mem_req) chk("iord", 32'(iord), 32'(ex.iord));
        if (ex.pc_write) chk("pc_src", 32'(pc_src), 32'(ex.pc_src));
        if (ex.reg_write) chk("wb_sel", 32'(wb_sel), 32'(ex.wb_sel));
        if (ex.chk_alu) begin
            chk("alu_src_b", 32'(alu_src_b), 32'(ex.alu_src_b));
            chk("alu_op", 32'(alu_op), 32'(ex.alu_op));
        end
    end

    task automatic cyc(input logic rdy, input exp_t e);
        mem_ready = rdy;
        e.illegal = m_ill;
        e.bus_err = m_be;
        e.instret = m_ir;
        ex = e;
        ex_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_t e;
        e = '0;
        rst = 1'b1;
        m_ir = '0;
        m_ill = 1'b0;
        m_be = 1'b0;
        trapped = 1'b0;
        cyc(1'($urandom), e);
        cyc(1'($urandom), e);
        rst = 1'b0;
        cyc(1'($urandom), e);
    endtask

    task automatic trap_cycles();
        exp_t e;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            opcode = 7'($urandom);
            funct3 = 3'($urandom);
            alu_zero = 1'($urandom);
            cyc(1'($urandom), e);
        end
    endtask

    // One instruction from the start of FETCH; fw/mw are mem_ready=0 cycles before the handshake completes.
    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic az, input int fw, input int mw,
                         input bit rst_mid);
        exp_t e, a;
        logic lg;
        opcode = 7'($urandom);
        funct3 = 3'($urandom);
        alu_zero = 1'($urandom);
        for (int i = 0; i <= fw; i++) begin
            e = '0;
            if (i == fw) begin
                e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b00;
                cyc(1'b1, e);
            end else if (i == TO) begin
                cyc(1'b0, e);
                m_be = 1'b1; trapped = 1'b1;
                return;
            end else begin
                e.mem_req = 1'b1;
                cyc(1'b0, e);
            end
        end
        opcode = op;
        funct3 = f3;
        e = '0;
        cyc(1'($urandom), e);
        lg = (op inside {7'h1b, 7'h13, 7'h33, 7'h03, 7'h23, 7'h38, 7'h6f, 7'h67}) || (op == 7'h63 && f3 < 3'd2);
        if (!lg) begin
            m_ill = 1'b1; trapped = 1'b1;
            return;
        end
        alu_zero = az;
        a = '0;
        a.chk_alu = op != 7'h6f;
        a.alu_src_b = !(op == 7'h33 || op == 7'h63);
        a.alu_op = (op == 7'h13 || op == 7'h33) ? 2'd2 : op == 7'h38 ? 2'd3 : op == 7'h63 ? 2'd1 : 2'd0;
        e = a;
        if (op == 7'h63) begin
            e.pc_write = (f3 == 3'd0) ? az : !az;
            e.pc_src = 2'b01;
        end else if (op == 7'h6f || op == 7'h67) begin
            e.reg_write = 1'b1; e.wb_sel = 2'b10; e.pc_write = 1'b1;
            e.pc_src = op == 7'h6f ? 2'b01 : 2'b10;
        end
        cyc(1'($urandom), e);
        if (op inside {7'h63, 7'h6f, 7'h67}) begin
            m_ir++;
            return;
        end
        alu_zero = 1'($urandom);
        if (op == 7'h03 || op == 7'h23) begin
            for (int i = 0; i <= mw; i++) begin
                if (rst_mid && i == 1) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_drop_mem_req", 32'(mem_req), 32'd0);
                    chk("rst_clears_instret", instret, 32'd0);
                    do_reset();
                    return;
                end
                e = a;
                e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = op == 7'h23;
                if (i == mw) cyc(1'b1, e);
                else if (i == TO) begin
                    e = '0;
                    cyc(1'b0, e);
                    m_be = 1'b1; trapped = 1'b1;
                    return;
                end else cyc(1'b0, e);
            end
            if (op == 7'h23) begin
                m_ir++;
                return;
            end
        end
        e = a;
        e.reg_write = 1'b1;
        e.wb_sel = op == 7'h03 ? 2'b01 : 2'b00;
        cyc(1'($urandom), e);
        m_ir++;
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 9));
        return r < 6 ? 0 : r < 8 ? int'($urandom_range(1, 3)) : r == 8 ? TO : TO + 1;
    endfunction

    initial begin
        logic [6:0] ops [10];
        ops = '{7'h1b, 7'h13, 7'h33, 7'h03, 7'h23, 7'h38, 7'h6f, 7'h67, 7'h63, 7'h63};
        do_reset();
        instr(7'h1b, 3'd0, 1'b0, 0, 0, 1'b0);
        chk("addi_instret_lit", instret, 32'd1);
        instr(7'h03, 3'd0, 1'b0, 0, 3, 1'b0);
        instr(7'h23, 3'd0, 1'b0, 0, 0, 1'b0);
        chk("ldst_instret_lit", instret, 32'd3);
        instr(7'h63, 3'd0, 1'b1, 0, 0, 1'b0);
        instr(7'h63, 3'd0, 1'b0, 0, 0, 1'b0);
        instr(7'h63, 3'd1, 1'b0, 0, 0, 1'b0);
        instr(7'h63, 3'd1, 1'b1, 0, 0, 1'b0);
        instr(7'h6f, 3'd0, 1'b0, 0, 0, 1'b0);
        instr(7'h67, 3'd0, 1'b0, 0, 0, 1'b0);
        chk("flow_instret_lit", instret, 32'd9);
        instr(7'h63, 3'd2, 1'b0, 0, 0, 1'b0);
        trap_cycles();
        chk("illegal_lit", 32'(illegal), 32'd1);
        do_reset();
        instr(7'h1b, 3'd0, 1'b0, TO + 1, 0, 1'b0);
        trap_cycles();
        chk("bus_err_lit", 32'(bus_err), 32'd1);
        do_reset();
        instr(7'h1b, 3'd0, 1'b0, TO, 0, 1'b0);
        chk("ready_at_limit_no_bus_err", 32'(bus_err), 32'd0);
        instr(7'h03, 3'd0, 1'b0, 0, TO, 1'b0);
        instr(7'h03, 3'd0, 1'b0, 0, 3, 1'b1);
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        m_ir = 32'hFFFF_FFFF;
        instr(7'h1b, 3'd0, 1'b0, 0, 0, 1'b0);
        chk("instret_wrap_lit", instret, 32'd0);
        for (int n = 0; n < 80; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            op = ops[$urandom_range(0, 9)];
            f3 = op == 7'h63 ? 3'($urandom_range(0, 1)) : 3'($urandom);
            if ($urandom_range(0, 11) == 0) op = 7'($urandom_range(0, 1) ? 7'h17 : 7'h00);
            if (op == 7'h63 && $urandom_range(0, 11) == 0) f3 = 3'd2;
            instr(op, f3, 1'($urandom), pick_wait(), pick_wait(), 1'b0);
            if (trapped) begin
                trap_cycles();
                do_reset();
            end
        end
        ex_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the RV-style core.
- Sequences fetch, decode, execute, memory and writeback over a shared single-port memory and a single ALU.
- Decodes the opcode and funct3 held in the instruction register and drives datapath select and strobe lines, including operand B select between register and sign-extended immediate.
- Adds a memory-handshake timeout, a sticky trap, and a retired-instruction counter.

Parameters:
- TO_W, 8, width of memory-wait timeout counter.
- TIMEOUT, 255, max cycles waiting for mem_ready before bus-error trap; must be < 2^TO_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, valid with mem_req
- iord  out  1  address select: 0 = PC, 1 = ALU result
- ir_write  out  1  latch instruction; datapath also latches pc_old
- pc_write  out  1  update PC
- pc_src  out  2  00 PC+4, 01 pc_old+imm, 10 ALU result
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 ADD, 01 SUB, 10 funct-decoded, 11 pass B
- reg_write  out  1  register file write
- wb_sel  out  2  00 ALU, 01 memory data, 10 link (current PC)
- illegal  out  1  sticky illegal-instruction trap
- bus_err  out  1  sticky memory-timeout trap
- instret  out  32  retired-instruction count

Behaviour:
- States (3-bit): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Unused encodings go to TRAP.
- Reset: state=IDLE, instret=0, illegal=0, bus_err=0, timeout counter=0.
- Strobes are combinational from state, opcode, funct3, alu_zero and mem_ready. All strobes are 0 in IDLE, DECODE and TRAP, and while rst is high.
- IDLE: go to FETCH next cycle.
- FETCH:
  - mem_req=1, iord=0, mem_we=0.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Legal opcodes: 1b ADDI, 13 ORI/ANDI, 33 R-type, 03 load, 23 store, 38 LUI, 6F JAL, 67 JALR, 63 branch with funct3 000 or 001. These go to EXEC.
  - Anything else sets illegal=1 and goes to TRAP.
- EXEC:
  - 1b: alu_src_b=1, alu_op=00, then WB.
  - 13: alu_src_b=1, alu_op=10, then WB.
  - 33: alu_src_b=0, alu_op=10, then WB.
  - 38: alu_src_b=1, alu_op=11, then WB.
  - 03/23: alu_src_b=1, alu_op=00, then MEM.
  - 63: alu_src_b=0, alu_op=01. pc_write=1, pc_src=01 when taken (funct3 000 and alu_zero, or funct3 001 and !alu_zero). Then FETCH; retires.
  - 6F: reg_write=1, wb_sel=10, pc_write=1, pc_src=01, then FETCH; retires.
  - 67: alu_src_b=1, alu_op=00, reg_write=1, wb_sel=10, pc_write=1, pc_src=10, then FETCH; retires. The link value is the pre-edge PC (already PC+4).
- MEM:
  - mem_req=1, iord=1, mem_we=1 for store. alu_src_b=1 and alu_op=00 are held.
  - Stay until mem_ready.
  - On mem_ready: store goes to FETCH and retires; load goes to WB.
- WB: reg_write=1, wb_sel=01 for load and 00 otherwise; alu_src_b and alu_op are held as in EXEC. Then FETCH; retires.
- Retire: instret increments by 1 on the clock edge of each retiring transition. It wraps from FFFF_FFFF to 0.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle in those states while mem_ready=0.
  - If the counter equals TIMEOUT with mem_ready=0: bus_err=1, go to TRAP, no strobes that cycle.
  - mem_ready arriving in the same cycle the counter hits TIMEOUT wins (normal completion).
- TRAP: all strobes 0. Stays until rst. illegal, bus_err and instret are held.
- Reset mid-operation (e.g. during MEM with mem_req high): all strobes drop immediately and asynchronously. Restart goes through IDLE.
- mem_ready is ignored outside FETCH and MEM.

Test Plan:
- Reset, then ADDI 0x1b with mem_ready=1 every cycle -> states 0,1,2,3,5,1. ir_write pulses cycle 1, reg_write with wb_sel=00 in WB. instret=1 after 5 cycles.
- Load 0x03 with mem_ready held low 3 cycles in MEM -> mem_req/iord high 4 cycles, then WB with wb_sel=01. Store 0x23 -> mem_we=1 in MEM, no WB, instret +1.
- BEQ (63, funct3 000): alu_zero=1 -> pc_write=1, pc_src=01 in EXEC. alu_zero=0 -> pc_write=0. BNE is the inverse. funct3 010 -> illegal=1, TRAP.
- JAL 0x6F -> one EXEC cycle with reg_write=1, wb_sel=10, pc_write=1, pc_src=01. JALR 0x67 -> same but pc_src=10, alu_src_b=1.
- TIMEOUT=4, mem_ready stuck low in FETCH -> bus_err=1 on the 5th FETCH cycle, TRAP, strobes 0. Variant with mem_ready=1 exactly at count 4 -> DECODE, no bus_err.
- rst asserted mid-MEM -> mem_req=0 immediately, instret=0, IDLE then FETCH. Preload instret=FFFF_FFFF via force -> next retire gives 0.
